// File: rtl/boot_loader.sv
// boot_loader: byte-stream program loader that owns the RAM bus after reset.
// It receives a framed image (ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, payload) over
// a valid/ready byte interface, writes the payload into RAM, then hands the
// bus to the 6502 core and releases it.
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN
//   When defined, a trailing CHECKSUM byte (8-bit payload sum mod 256) is
//   consumed after the payload. A mismatch ends in the error state.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   in_valid  in_data holds a byte
//   in_data   stream byte
//   in_ready  loader accepts a byte this cycle
//   RW        RAM read/write (1 = read, 0 = write)
//   AD        RAM address
//   D_out     RAM write data
//   bus_own   loader drives the RAM bus (core selected when 0)
//   cpu_run   core released
//   done      load completed successfully
//   error     load aborted
module boot_loader #(
  parameter int RAM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        RW,
  output logic [15:0] AD,
  output logic [7:0]  D_out,
  output logic        bus_own,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    A_LO   = 4'd1,
    A_HI   = 4'd2,
    L_LO   = 4'd3,
    L_HI   = 4'd4,
    DATA   = 4'd5,
    WRITE  = 4'd6,
    FINISH = 4'd7,
    DONE   = 4'd8,
    ERROR  = 4'd9
  } state_t;

  localparam logic [16:0] RAM_LIMIT = 17'(RAM_SIZE);

`ifdef BOOT_LOADER_CHECKSUM_EN
  // Running checksum update: plain 8-bit wrap-around addition.
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  state_t      state_r, state_s;
  logic [15:0] addr_r, addr_s;
  logic [15:0] len_r, len_s;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]  sum_r, sum_s;
`endif
  logic        in_ready_s, rw_s, bus_own_s, cpu_run_s, done_s, error_s;
  logic [15:0] ad_s;
  logic [7:0]  d_out_s;
  logic        xfer_s;
  logic [15:0] len_new_s;
  logic [16:0] end_addr_s;
  logic        range_bad_s;

  assign xfer_s = in_valid & in_ready;

  // The range check uses the LEN_HI byte arriving this cycle, so the frame can
  // go straight to DATA/FINISH/ERROR without an extra check state.
  assign len_new_s   = {in_data, len_r[7:0]};
  assign end_addr_s  = {1'b0, addr_r} + {1'b0, len_new_s};
  assign range_bad_s = ({1'b0, addr_r} >= RAM_LIMIT) || (end_addr_s > RAM_LIMIT);

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    len_s   = len_r;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_s   = sum_r;
`endif
    case (state_r)
      IDLE: state_s = A_LO;
      A_LO: begin
        if (xfer_s) begin
          addr_s  = {addr_r[15:8], in_data};
          state_s = A_HI;
        end else begin
          state_s = A_LO;
        end
      end
      A_HI: begin
        if (xfer_s) begin
          addr_s  = {in_data, addr_r[7:0]};
          state_s = L_LO;
        end else begin
          state_s = A_HI;
        end
      end
      L_LO: begin
        if (xfer_s) begin
          len_s   = {len_r[15:8], in_data};
          state_s = L_HI;
        end else begin
          state_s = L_LO;
        end
      end
      L_HI: begin
        if (xfer_s) begin
          len_s = len_new_s;
          if (range_bad_s) begin
            state_s = ERROR;
          end else if (len_new_s == 16'd0) begin
            state_s = FINISH;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = L_HI;
        end
      end
      DATA: begin
        if (xfer_s) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          sum_s   = sum_add(sum_r, in_data);
`endif
          state_s = WRITE;
        end else begin
          state_s = DATA;
        end
      end
      WRITE: begin
        addr_s = addr_r + 16'd1;
        len_s  = len_r - 16'd1;
        if (len_r == 16'd1) begin
          state_s = FINISH;
        end else begin
          state_s = DATA;
        end
      end
      FINISH: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (xfer_s) begin
          if (in_data == sum_r) begin
            state_s = DONE;
          end else begin
            state_s = ERROR;
          end
        end else begin
          state_s = FINISH;
        end
`else
        state_s = DONE;
`endif
      end
      DONE:    state_s = DONE;
      ERROR:   state_s = ERROR;
      default: state_s = ERROR;
    endcase

    // Outputs are decoded from the state being entered, so the registered
    // copies always describe the state the register holds.
    in_ready_s = 1'b0;
    rw_s       = 1'b1;
    ad_s       = AD;
    d_out_s    = D_out;
    bus_own_s  = 1'b1;
    cpu_run_s  = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    case (state_s)
      IDLE, A_LO, A_HI, L_LO, L_HI, DATA: in_ready_s = 1'b1;
      WRITE: begin
        // WRITE is only entered from DATA on a transfer: in_data is the byte.
        rw_s    = 1'b0;
        ad_s    = addr_r;
        d_out_s = in_data;
      end
      FINISH: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        in_ready_s = 1'b1;
`else
        in_ready_s = 1'b0;
`endif
      end
      DONE: begin
        bus_own_s = 1'b0;
        cpu_run_s = 1'b1;
        done_s    = 1'b1;
      end
      ERROR:   error_s    = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      addr_r   <= 16'd0;
      len_r    <= 16'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_r    <= 8'd0;
`endif
      in_ready <= 1'b0;
      RW       <= 1'b1;
      AD       <= 16'd0;
      D_out    <= 8'd0;
      bus_own  <= 1'b1;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      len_r    <= len_s;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_r    <= sum_s;
`endif
      in_ready <= in_ready_s;
      RW       <= rw_s;
      AD       <= ad_s;
      D_out    <= d_out_s;
      bus_own  <= bus_own_s;
      cpu_run  <= cpu_run_s;
      done     <= done_s;
      error    <= error_s;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: self-checking bench for boot_loader. A frame-level model
// derives the expected write sequence, final status and RAM image from the
// frame bytes; a negedge monitor checks every bus cycle against it.
module tb_boot_loader;
  localparam int RAM_SIZE = 1024;
  localparam int WAIT_MAX = 64;
  localparam logic [29:0] RESET_VEC = {1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, RW, bus_own, cpu_run, done, error;
  logic [15:0] AD;
  logic [7:0]  D_out;

  boot_loader #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .RW(RW), .AD(AD), .D_out(D_out),
    .bus_own(bus_own), .cpu_run(cpu_run), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ram     [RAM_SIZE];
  logic [7:0]  exp_ram [RAM_SIZE];
  bit          exp_vld [RAM_SIZE];
  logic [23:0] exp_q [$];
  int          exp_writes;
  bit          exp_ok;
  bit          exp_range_ok;
  int          wr_count;
  int          stall_count;
  logic [15:0] mon_last_ad;
  logic [23:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM attached to the loader bus.
  always @(posedge clk) begin
    if (RW == 1'b0) ram[AD[9:0]] <= D_out;
  end

  // Per-cycle compare of the bus against the model's expected write list.
  always @(negedge clk) begin
    if (rst_n == 1'b1) begin
      if (RW == 1'b0) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: AD=0x%0h D_out=0x%0h, expected no write", AD, D_out);
        end else begin
          mon_w = exp_q.pop_front();
          check("write_addr_data", {8'h00, AD, D_out}, {8'h00, mon_w});
          check("in_ready_low_in_write", 32'(in_ready), 32'd0);
          mon_last_ad = mon_w[23:8];
        end
      end else begin
        check("ad_holds_last_write", 32'(AD), 32'(mon_last_ad));
        if (!in_ready && !done && !error) stall_count++;
      end
      if (done) check("done_outputs", 32'({in_ready, bus_own, cpu_run, error}), 32'h2);
      else      check("loading_outputs", 32'({bus_own, cpu_run}), 32'h2);
    end
  end

  // Frame-level model: expected writes, final outcome, RAM image.
  task automatic model(input logic [7:0] fb[$]);
    logic [15:0] a;
    logic [15:0] l;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  s;
    s = 8'h00;
`endif
    a = {fb[1], fb[0]};
    l = {fb[3], fb[2]};
    exp_q.delete();
    exp_writes = 0;
    exp_range_ok = (int'(a) < RAM_SIZE) && (int'(a) + int'(l) <= RAM_SIZE);
    if (!exp_range_ok) begin
      exp_ok = 1'b0;
    end else begin
      for (int i = 0; i < int'(l); i++) begin
        exp_q.push_back({a + 16'(i), fb[4 + i]});
        exp_ram[int'(a) + i] = fb[4 + i];
        exp_vld[int'(a) + i] = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
        s = s + fb[4 + i];
`endif
      end
      exp_writes = int'(l);
`ifdef BOOT_LOADER_CHECKSUM_EN
      exp_ok = (fb[4 + int'(l)] == s);
`else
      exp_ok = 1'b1;
`endif
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_outputs", 32'({in_ready, RW, AD, D_out, bus_own, cpu_run, done, error}), 32'(RESET_VEC));
    exp_q.delete();
    wr_count = 0;
    stall_count = 0;
    mon_last_ad = 16'h0000;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (in_ready !== 1'b1 && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
    check("byte_accepted", 32'(in_ready), 32'd1);
    if (in_ready === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] fb[$], input int gap);
    int n;
    int exp_stall;
    do_reset();
    model(fb);
    foreach (fb[i]) send_byte(fb[i], (i == 0) ? 0 : gap);
    in_valid = 1'b0;
    if (!exp_range_ok) check({tag, "_error_after_len_hi"}, 32'(error), 32'd1);
    n = 0;
    while (!(done || error) && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_status"}, 32'({in_ready, RW, bus_own, cpu_run, done, error}),
          32'({1'b0, 1'b1, !exp_ok, exp_ok, exp_ok, !exp_ok}));
    check({tag, "_write_count"}, 32'(wr_count), 32'(exp_writes));
    check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    exp_stall = 1;
`else
    exp_stall = exp_ok ? 2 : 1;
`endif
    check({tag, "_in_ready_drops"}, 32'(stall_count), 32'(exp_stall));
    n = 0;
    for (int a = 0; a < RAM_SIZE; a++) begin
      if (exp_vld[a] && ram[a] !== exp_ram[a]) n++;
    end
    check({tag, "_ram_bad_bytes"}, 32'(n), 32'd0);
  endtask

  initial begin
    logic [7:0] f1[$];
    logic [7:0] fr[$];

    f1 = '{8'h00, 8'h00, 8'h09, 8'h00, 8'hEA, 8'hA9, 8'h55, 8'h69, 8'h03, 8'h29, 8'hF0, 8'h09, 8'h05};
`ifdef BOOT_LOADER_CHECKSUM_EN
    // Payload sum mod 256 is 0x7B.
    f1.push_back(8'h7B);
`endif

    // Back-to-back image load.
    run_frame("f1", f1, 0);
    check("f1_writes_9", 32'(wr_count), 32'd9);
    check("f1_ram0", 32'(ram[0]), 32'hEA);
    check("f1_ram8", 32'(ram[8]), 32'h05);
    check("f1_released", 32'({done, cpu_run, bus_own}), 32'h6);

    // Same image with 3 idle cycles between bytes.
    run_frame("f1_gap", f1, 3);
    check("f1_gap_ram4", 32'(ram[4]), 32'h03);

    // Range overflow: 0x3FE + 4 > 1024.
    fr = '{8'hFE, 8'h03, 8'h04, 8'h00};
    run_frame("overflow", fr, 0);
    check("overflow_error", 32'({error, cpu_run, bus_own}), 32'h5);
    check("overflow_writes_0", 32'(wr_count), 32'd0);

    // Start address at RAM_SIZE is rejected even with zero length.
    fr = '{8'h00, 8'h04, 8'h00, 8'h00};
    run_frame("addr_oob", fr, 0);
    check("addr_oob_error", 32'(error), 32'd1);

    // Zero-length frame.
    fr = '{8'h10, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    fr.push_back(8'h00);
`endif
    run_frame("len0", fr, 0);
    check("len0_done", 32'({done, cpu_run}), 32'h3);
    check("len0_writes_0", 32'(wr_count), 32'd0);

    // Last RAM byte is writable.
    fr = '{8'hFF, 8'h03, 8'h01, 8'h00, 8'hAB};
`ifdef BOOT_LOADER_CHECKSUM_EN
    fr.push_back(8'hAB);
`endif
    run_frame("top_byte", fr, 0);
    check("top_byte_ram", 32'(ram[1023]), 32'hAB);

    // Reset during the WRITE of the third payload byte, then full reload.
    do_reset();
    model(f1);
    for (int i = 0; i < 7; i++) send_byte(f1[i], 0);
    in_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midload_reset_outputs", 32'({in_ready, RW, AD, D_out, bus_own, cpu_run, done, error}), 32'(RESET_VEC));
    check("midload_writes_3", 32'(wr_count), 32'd3);
    run_frame("reload", f1, 0);
    check("reload_done", 32'(done), 32'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Wrong checksum after a valid payload.
    fr = f1;
    fr[13] = 8'h08;
    run_frame("bad_sum", fr, 0);
    check("bad_sum_status", 32'({error, cpu_run, bus_own, done}), 32'hA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
